// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter feeding one SDRAM request path; one transaction in flight.
// Write ack 2 cycles after grant; ram_busy stalls ISSUE cycle-for-cycle; reads time out after RD_TIMEOUT.
module sdram_arbiter #(
   parameter int ADDR_WIDTH = 24,
   parameter int DATA_WIDTH = 16,
   parameter int RD_TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  p0_req,
   input  logic                  p0_we,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   output logic                  p0_ack,
   output logic                  p0_err,
   output logic [DATA_WIDTH-1:0] p0_rdata,
   input  logic                  p1_req,
   input  logic                  p1_we,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   output logic                  p1_ack,
   output logic                  p1_err,
   output logic [DATA_WIDTH-1:0] p1_rdata,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic                  ram_wr_en,
   output logic                  ram_rd_en,
   input  logic                  ram_busy,
   input  logic                  ram_rd_ready,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic                  ram_rd_ack
);
   localparam int CNT_W = (RD_TIMEOUT < 2) ? 1 : $clog2(RD_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

   state_t                state_q, state_d;
   logic                  last_q, last_d;
   logic                  sel_q, sel_d;
   logic                  we_q, we_d;
   logic                  err_q, err_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] p0_rdata_q, p0_rdata_d;
   logic [DATA_WIDTH-1:0] p1_rdata_q, p1_rdata_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  wr_en_c, rd_en_c, rd_ack_c, ack0_c, ack1_c;
   logic                  gnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         last_q     <= 1'b1;
         sel_q      <= 1'b0;
         we_q       <= 1'b0;
         err_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         p0_rdata_q <= '0;
         p1_rdata_q <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         sel_q      <= sel_d;
         we_q       <= we_d;
         err_q      <= err_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         p0_rdata_q <= p0_rdata_d;
         p1_rdata_q <= p1_rdata_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      sel_d      = sel_q;
      we_d       = we_q;
      err_d      = err_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      p0_rdata_d = p0_rdata_q;
      p1_rdata_d = p1_rdata_q;
      cnt_d      = cnt_q;
      wr_en_c    = 1'b0;
      rd_en_c    = 1'b0;
      rd_ack_c   = 1'b0;
      ack0_c     = 1'b0;
      ack1_c     = 1'b0;
      gnt        = (p0_req && p1_req) ? ~last_q : p1_req;
      case (state_q)
         IDLE: begin
            // Late words from an abandoned or reset-interrupted read are discarded here.
            rd_ack_c = ram_rd_ready;
            if (p0_req || p1_req) begin
               sel_d   = gnt;
               last_d  = gnt;
               we_d    = gnt ? p1_we    : p0_we;
               addr_d  = gnt ? p1_addr  : p0_addr;
               wdata_d = gnt ? p1_wdata : p0_wdata;
               err_d   = 1'b0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (!ram_busy) begin
               wr_en_c = we_q;
               rd_en_c = ~we_q;
               cnt_d   = '0;
               state_d = we_q ? DONE : WAIT_RD;
            end
         end
         WAIT_RD: begin
            if (ram_rd_ready) begin
               rd_ack_c = 1'b1;
               if (sel_q) p1_rdata_d = ram_rd_data;
               else       p0_rdata_d = ram_rd_data;
               state_d = DONE;
            end else if (cnt_q == CNT_MAX) begin
               err_d   = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            ack0_c  = ~sel_q;
            ack1_c  = sel_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Strobes are held low while reset is asserted, whatever the pre-reset state.
   assign ram_wr_en   = rst & wr_en_c;
   assign ram_rd_en   = rst & rd_en_c;
   assign ram_rd_ack  = rst & rd_ack_c;
   assign p0_ack      = rst & ack0_c;
   assign p1_ack      = rst & ack1_c;
   assign p0_err      = rst & ack0_c & err_q;
   assign p1_err      = rst & ack1_c & err_q;
   assign p0_rdata    = p0_rdata_q;
   assign p1_rdata    = p1_rdata_q;
   assign ram_addr    = addr_q;
   assign ram_wr_data = wdata_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: cycle vector table, hand-built read/timeout/reset sequences, random traffic.
module tb_sdram_arbiter;
   localparam int AW = 24;
   localparam int DW = 16;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
   logic [AW-1:0] p0_addr = '0, p1_addr = '0;
   logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
   logic          p0_ack, p0_err, p1_ack, p1_err;
   logic [DW-1:0] p0_rdata, p1_rdata;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wr_data;
   logic          ram_wr_en, ram_rd_en, ram_rd_ack;
   logic          ram_busy = 1'b0, ram_rd_ready = 1'b0;
   logic [DW-1:0] ram_rd_data = '0;

   always #5 clk = ~clk;

   sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
      .ram_addr(ram_addr), .ram_wr_data(ram_wr_data), .ram_wr_en(ram_wr_en),
      .ram_rd_en(ram_rd_en), .ram_busy(ram_busy), .ram_rd_ready(ram_rd_ready),
      .ram_rd_data(ram_rd_data), .ram_rd_ack(ram_rd_ack)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] strobes();
      return {ram_wr_en, ram_rd_en, ram_rd_ack, p0_ack, p0_err, p1_ack, p1_err};
   endfunction

   // ---------------- vector table ----------------
   typedef struct {
      logic          rst;
      logic          r0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic          r1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic          busy;
      logic [6:0]    e;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(logic r, logic r0, logic [AW-1:0] a0, logic [DW-1:0] d0,
                               logic r1, logic [AW-1:0] a1, logic [DW-1:0] d1, logic busy,
                               logic [6:0] e, logic [AW-1:0] ea, logic [DW-1:0] ed);
      vec_t v;
      v.rst = r; v.r0 = r0; v.a0 = a0; v.d0 = d0; v.r1 = r1; v.a1 = a1; v.d1 = d1;
      v.busy = busy; v.e = e; v.ea = ea; v.ed = ed;
      return v;
   endfunction

   localparam logic [6:0] Z  = 7'b0000000;
   localparam logic [6:0] W  = 7'b1000000;
   localparam logic [6:0] K0 = 7'b0001000;
   localparam logic [6:0] K1 = 7'b0000010;
   localparam logic [AW-1:0] A  = 24'h000123, X0 = 24'h000010, X1 = 24'h000020, B = 24'h000030;
   localparam logic [DW-1:0] D  = 16'hBEEF, Y0 = 16'h1111, Y1 = 16'h2222, E = 16'h3333;

   task automatic fill_table();
      vt.push_back(mk(0, 1, A, D, 0, 0, 0, 0, Z, 0, 0));
      vt.push_back(mk(0, 1, A, D, 0, 0, 0, 0, Z, 0, 0));
      vt.push_back(mk(1, 1, A, D, 0, 0, 0, 0, Z, 0, 0));
      vt.push_back(mk(1, 1, A, D, 0, 0, 0, 0, W, A, D));
      vt.push_back(mk(1, 1, A, D, 0, 0, 0, 0, K0, A, D));
      // both ports now request writes back to back; last grant was p0 so p1 goes first
      for (int k = 0; k < 3; k++) begin
         vt.push_back(mk(1, 1, X0, Y0, 1, X1, Y1, 0, Z, (k == 0) ? A : (k == 1) ? X1 : X0,
                         (k == 0) ? D : (k == 1) ? Y1 : Y0));
         vt.push_back(mk(1, 1, X0, Y0, 1, X1, Y1, 0, W, (k == 1) ? X0 : X1, (k == 1) ? Y0 : Y1));
         vt.push_back(mk(1, 1, X0, Y0, 1, X1, Y1, 0, (k == 1) ? K0 : K1,
                         (k == 1) ? X0 : X1, (k == 1) ? Y0 : Y1));
      end
      vt.push_back(mk(1, 1, B, E, 0, 0, 0, 0, Z, X1, Y1));
      for (int k = 0; k < 4; k++) vt.push_back(mk(1, 1, B, E, 0, 0, 0, 1, Z, B, E));
      vt.push_back(mk(1, 1, B, E, 0, 0, 0, 0, W, B, E));
      vt.push_back(mk(1, 1, B, E, 0, 0, 0, 0, K0, B, E));
      vt.push_back(mk(1, 0, B, E, 0, 0, 0, 0, Z, B, E));
   endtask

   // ---------------- directed read helper ----------------
   task automatic read_txn(input bit port, input logic [AW-1:0] addr, input int delay,
                           input logic [DW-1:0] data, input bit exp_err,
                           input logic [DW-1:0] exp_own, input logic [DW-1:0] exp_other);
      int n, lat, npop;
      bit found, got, clr_r;
      p0_req = 0; p1_req = 0;
      if (port) begin p1_req = 1; p1_we = 0; p1_addr = addr; end
      else      begin p0_req = 1; p0_we = 0; p0_addr = addr; end
      found = 0; n = 0;
      while (n < 10 && !found) begin
         #1;
         if (ram_rd_en) found = 1;
         else begin tick(); n++; end
      end
      chk("rd_issue_cycle", n, 1);
      chk("rd_issue_addr", ram_addr, addr);
      lat = 0; npop = 0; got = 0; clr_r = 0;
      while (lat < 20 && !got) begin
         tick();
         lat++;
         if (clr_r) begin ram_rd_ready = 0; clr_r = 0; end
         if (delay > 0 && lat == delay) begin ram_rd_ready = 1; ram_rd_data = data; end
         #1;
         if (ram_rd_ack) begin npop++; clr_r = 1; end
         if (p0_ack || p1_ack) got = 1;
      end
      chk("rd_ack_latency", lat, exp_err ? TO + 2 : delay + 1);
      chk("rd_ack_port", {p1_ack, p0_ack}, port ? 2'b10 : 2'b01);
      chk("rd_err", port ? p1_err : p0_err, exp_err);
      chk("rd_pop_count", npop, exp_err ? 0 : 1);
      chk("rd_rdata_own", port ? p1_rdata : p0_rdata, exp_own);
      chk("rd_rdata_other", port ? p0_rdata : p1_rdata, exp_other);
      tick();
      p0_req = 0; p1_req = 0; ram_rd_ready = 0;
   endtask

   // ---------------- random traffic with transaction-level model ----------------
   logic [DW-1:0] mem [32];
   bit            pend [2], rwe [2], ack_seen [2];
   logic [3:0]    ridx [2];
   logic [DW-1:0] rwd [2], mrd [2];

   task automatic run_random(input int ncyc);
      bit midle, mlast, have_exp, issued, clr, ep;
      int resp_cnt, wd_cnt;
      logic [DW-1:0] resp_dat;
      logic [AW-1:0] ea;
      for (int i = 0; i < 32; i++) mem[i] = DW'($urandom);
      for (int p = 0; p < 2; p++) begin pend[p] = 0; ack_seen[p] = 0; mrd[p] = '0; end
      midle = 1; mlast = 1; have_exp = 0; issued = 0; clr = 0; ep = 0;
      resp_cnt = -1; wd_cnt = 0; resp_dat = '0;
      for (int c = 0; c < ncyc; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (ack_seen[p]) begin pend[p] = 0; ack_seen[p] = 0; end
            if (!pend[p] && $urandom_range(2) == 0) begin
               pend[p] = 1; rwe[p] = 1'($urandom_range(1));
               ridx[p] = 4'($urandom_range(15)); rwd[p] = DW'($urandom);
            end
         end
         if (clr) begin ram_rd_ready = 0; clr = 0; end
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin ram_rd_ready = 1; ram_rd_data = resp_dat; resp_cnt = -1; end
         end
         ram_busy = ($urandom_range(3) == 0);
         p0_req = pend[0]; p0_we = rwe[0]; p0_addr = {1'b0, 19'b0, ridx[0]}; p0_wdata = rwd[0];
         p1_req = pend[1]; p1_we = rwe[1]; p1_addr = {1'b1, 19'b0, ridx[1]}; p1_wdata = rwd[1];
         #1;
         if (midle && (pend[0] || pend[1])) begin
            ep = (pend[0] && pend[1]) ? ~mlast : pend[1];
            mlast = ep; midle = 0; have_exp = 1; issued = 0; wd_cnt = 0;
         end
         chk("rnd_strobe_excl", ram_wr_en & ram_rd_en, 0);
         if (ram_busy) chk("rnd_strobe_busy", ram_wr_en | ram_rd_en, 0);
         if (ram_wr_en || ram_rd_en) begin
            ea = {ep, 19'b0, ridx[ep]};
            chk("rnd_strobe_expected", {have_exp, issued}, 2'b10);
            chk("rnd_strobe_addr", ram_addr, ea);
            chk("rnd_strobe_kind", ram_wr_en, rwe[ep]);
            if (ram_wr_en) begin
               chk("rnd_wdata", ram_wr_data, rwd[ep]);
               mem[{ep, ridx[ep]}] = rwd[ep];
            end else begin
               resp_dat = mem[{ep, ridx[ep]}];
               resp_cnt = $urandom_range(6, 1);
            end
            issued = 1;
         end
         if (ram_rd_ack) begin
            chk("rnd_pop_when_ready", ram_rd_ready, 1);
            clr = 1;
         end
         if (p0_ack || p1_ack) begin
            chk("rnd_ack_expected", {have_exp, issued}, 2'b11);
            chk("rnd_ack_port", {p1_ack, p0_ack}, ep ? 2'b10 : 2'b01);
            chk("rnd_ack_err", p0_err | p1_err, 0);
            if (!rwe[ep]) mrd[ep] = resp_dat;
            chk("rnd_rdata", {p1_rdata, p0_rdata}, {mrd[1], mrd[0]});
            ack_seen[ep] = 1; midle = 1; have_exp = 0; issued = 0;
         end
         if (have_exp) begin
            wd_cnt++;
            if (wd_cnt > 60) begin
               checks++; failures++;
               $display("FAIL rnd_watchdog: transaction for port %0d open %0d cycles, limit 60", ep, wd_cnt);
               break;
            end
         end
         tick();
      end
      ram_busy = 0; ram_rd_ready = 0; p0_req = 0; p1_req = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation still running at %0t, limit 1000000", $time);
      $fatal(1, "timeout");
   end

   initial begin
      rst = 0;
      tick();
      fill_table();
      for (int i = 0; i < vt.size(); i++) begin
         rst = vt[i].rst; ram_busy = vt[i].busy; ram_rd_ready = 0;
         p0_req = vt[i].r0; p0_we = 1; p0_addr = vt[i].a0; p0_wdata = vt[i].d0;
         p1_req = vt[i].r1; p1_we = 1; p1_addr = vt[i].a1; p1_wdata = vt[i].d1;
         #1;
         chk($sformatf("vec%0d", i), {strobes(), ram_addr, ram_wr_data}, {vt[i].e, vt[i].ea, vt[i].ed});
         tick();
      end
      chk("vec_rdata_untouched", {p0_rdata, p1_rdata}, 0);

      // p1 read, data returned 5 cycles after the read strobe
      read_txn(1, 24'h00ABCD, 5, 16'h1234, 0, 16'h1234, 16'h0000);
      // p0 read that never gets data: timeout with error, rdata kept
      read_txn(0, 24'h000055, 0, 16'h0000, 1, 16'h0000, 16'h1234);
      // late word arrives in IDLE and is drained without an ack
      ram_rd_ready = 1; ram_rd_data = 16'hDEAD;
      #1;
      chk("drain_pop", {ram_rd_ack, ram_rd_en, ram_wr_en, p0_ack, p1_ack}, 5'b10000);
      tick();
      ram_rd_ready = 0;
      #1;
      chk("drain_single", ram_rd_ack, 0);
      tick();
      read_txn(0, 24'h000066, 2, 16'h4321, 0, 16'h4321, 16'h1234);

      // reset in the middle of a read
      p1_req = 1; p1_we = 0; p1_addr = 24'h000077;
      tick();
      #1;
      chk("rst_seq_issue", ram_rd_en, 1);
      tick();
      tick();
      rst = 0; p1_req = 0;
      #1;
      chk("rst_during_strobes", strobes(), 0);
      tick();
      rst = 1;
      #1;
      chk("rst_after_regs", {ram_addr, ram_wr_data, p0_rdata, p1_rdata}, 0);
      chk("rst_after_strobes", strobes(), 0);
      tick();
      ram_rd_ready = 1; ram_rd_data = 16'h9999;
      #1;
      chk("rst_drain_pop", {ram_rd_ack, p0_ack, p1_ack}, 3'b100);
      tick();
      ram_rd_ready = 0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("rst_no_ack%0d", k), strobes(), 0);
         tick();
      end

      rst = 0;
      tick();
      rst = 1;
      run_random(3000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Two-port arbiter and sequencer for the SDRAM block's host interface: the CPU on port 0 and a loader/DMA on port 1 share a single SDRAM request path. The arbiter grants round-robin, issues one write or read at a time into the SDRAM write/read-address FIFOs, and waits for read data to return. It then pops the read-data FIFO and routes the word to the requesting port. It sits between the processor-side request logic and `sdram_block` in the `mclk` domain.

## Interface
- `ADDR_WIDTH`, 24, SDRAM word address width.
- `DATA_WIDTH`, 16, SDRAM data width.
- `RD_TIMEOUT`, 255, maximum cycles spent in WAIT_RD before the read is abandoned; must be ≥1.
- `clk`  in  1  mclk domain clock; all logic is on its rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `pN_req`  in  1  port N (N=0,1) request; held high with fields stable until `pN_ack`.
- `pN_we`  in  1  1 = write, 0 = read.
- `pN_addr`  in  ADDR_WIDTH  request address.
- `pN_wdata`  in  DATA_WIDTH  write data.
- `pN_ack`  out  1  one-cycle completion pulse.
- `pN_err`  out  1  high with `pN_ack` when a read timed out.
- `pN_rdata`  out  DATA_WIDTH  last read data for port N; valid from `pN_ack` until the next read completion on port N.
- `ram_addr`  out  ADDR_WIDTH  to `sdram_block`.
- `ram_wr_data`  out  DATA_WIDTH  to `sdram_block`.
- `ram_wr_en`  out  1  one-cycle write push.
- `ram_rd_en`  out  1  one-cycle read-address push.
- `ram_busy`  in  1  a request FIFO is full.
- `ram_rd_ready`  in  1  read-data FIFO is non-empty.
- `ram_rd_data`  in  DATA_WIDTH  read-data FIFO head.
- `ram_rd_ack`  out  1  pops the read-data FIFO.

## Operation
- States: IDLE, ISSUE, WAIT_RD, DONE.
- **Capture registers:** `sel`, `we_r`, `addr_r`, `wdata_r`. `ram_addr` = `addr_r` and `ram_wr_data` = `wdata_r` at all times.
- **IDLE:**
  - Round-robin pointer `last`: if both `req` are high, grant the port ≠ `last`; if one is high, grant it.
  - On grant, capture that port's fields, set `last` = granted port, then go to ISSUE.
  - If no request, stay in IDLE.
- **ISSUE:**
  - `ram_wr_en` = `we_r & ~ram_busy`; `ram_rd_en` = `~we_r & ~ram_busy` (combinational).
  - While `ram_busy` = 1, stay in ISSUE and assert nothing.
  - When the strobe fires: write goes to DONE; read goes to WAIT_RD and clears the timeout counter.
- **WAIT_RD:**
  - When `ram_rd_ready` = 1: `ram_rd_ack` = 1 (combinational, one cycle), `ram_rd_data` is registered into `p<sel>_rdata`, go to DONE.
  - Otherwise the counter increments. When it reaches `RD_TIMEOUT`, go to DONE with the error flag set and `rdata` unchanged.
- **DONE:** `p<sel>_ack` = 1 (plus `p<sel>_err` on timeout) for exactly one cycle, then go to IDLE.
  - The requester drops or changes `req` in the cycle after it sees `ack`.
- **Stale-data drain:** in IDLE, if `ram_rd_ready` = 1 (late data after a timeout or a reset mid-read), assert `ram_rd_ack` and discard the word.
  - A grant may still occur in the same cycle.
- At most one transaction is outstanding, so no reordering is possible.
- **Reset** (`rst` = 0 at a clock edge):
  - state goes to IDLE, `last` = 1 (port 0 wins first), counter = 0, capture registers = 0.
  - Every output is 0: `ram_*` strobes, `ram_addr`, `ram_wr_data`, `pN_ack`, `pN_err`, `pN_rdata`.
  - Reset overrides any state, including an in-flight ISSUE or WAIT_RD.

## Timing
- `req` sampled high in IDLE at edge T: ISSUE during T+1.
- **Write, `ram_busy` = 0:**
  - `ram_wr_en` is high during T+1.
  - DONE/`ack` during T+2; next grant no earlier than T+3.
- **Read:**
  - `ram_rd_en` is high during T+1; WAIT_RD from T+2.
  - If `ram_rd_ready` is first high in cycle R, `ram_rd_ack` is high in R, and `ack` plus valid `rdata` appear in R+1.
- Each cycle of `ram_busy` adds one cycle to ISSUE; strobes are never asserted while `ram_busy` = 1.
- `ram_wr_en`, `ram_rd_en` and `ram_rd_ack` are each high for at most one cycle per transaction (drain excepted). They are never high simultaneously, except `ram_rd_ack` during drain with `_en` low.
- **Timeout:** `ack` + `err` arrive `RD_TIMEOUT` + 1 cycles after WAIT_RD entry.
- Throughput with no stalls: one write per 3 cycles.

## Test plan
- Reset, then `p0` write addr 0x000123 data 0xBEEF with `ram_busy` = 0 → `ram_wr_en` one cycle at T+1 with `ram_addr` = 0x000123 and `ram_wr_data` = 0xBEEF; `p0_ack` at T+2; all outputs were 0 during reset.
- `p0` and `p1` both requesting writes continuously → grants alternate p0, p1, p0, p1; each `ack` is 3 cycles apart.
- `p1` read addr 0x00ABCD; model returns 0x1234 with `ram_rd_ready` 5 cycles after `ram_rd_en` → one-cycle `ram_rd_ack`, `p1_rdata` = 0x1234 with `p1_ack` the next cycle, `p0_rdata` unchanged.
- `ram_busy` held high for 4 cycles during ISSUE → no strobe for 4 cycles, then a single strobe; `ack` is delayed by 4 cycles.
- `RD_TIMEOUT` = 8 with no `ram_rd_ready` → `p0_ack` and `p0_err` after 9 WAIT_RD cycles. A late `ram_rd_ready` in IDLE → `ram_rd_ack` drains it; a subsequent read returns the correct new data.
- `rst` low during WAIT_RD → state goes to IDLE and outputs to 0; data arriving after reset is drained, and no `ack` is issued for it.
